// File: rtl/nest_tile_counter_pkg.sv
// rtl/nest_tile_counter_pkg.sv - shared types and bus-slicing helpers for the nested tile counter
package nest_cnt_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIN  = 2'd2
  } state_e;

  localparam int NEST_MAX = 4;

  // Low bit of level `lvl` inside a bus packed `width` bits per level.
  function automatic int lvl_lo(input int lvl, input int width);
    return lvl * width;
  endfunction

endpackage

// File: rtl/nest_tile_counter_level.sv
// rtl/nest_tile_counter_level.sv - one nest level: index counter plus its running address offset
module nest_cnt_level
  import nest_cnt_pkg::*;
#(
  parameter int CW = 16,
  parameter int AW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clear_i,
  input  logic          carry_in_i,
  input  logic [CW-1:0] max_i,
  input  logic [AW-1:0] stride_i,
  output logic [CW-1:0] cnt_o,
  output logic [AW-1:0] off_o,
  output logic          at_max_o,
  output logic          carry_out_o
);

  logic [CW-1:0] cnt_q;
  logic [AW-1:0] off_q;

  assign at_max_o    = (cnt_q == max_i - CW'(1));
  assign carry_out_o = carry_in_i & at_max_o;
  assign cnt_o       = cnt_q;
  assign off_o       = off_q;

  // off_q tracks cnt_q*stride_i incrementally so the address needs no multiplier.
  always_ff @(posedge clk) begin
    if (rst || clear_i) begin
      cnt_q <= '0;
      off_q <= '0;
    end else if (carry_in_i) begin
      if (at_max_o) begin
        cnt_q <= '0;
        off_q <= '0;
      end else begin
        cnt_q <= cnt_q + CW'(1);
        off_q <= off_q + stride_i;
      end
    end
  end

endmodule

// File: rtl/nest_tile_counter.sv
// rtl/nest_tile_counter.sv - N-level nested tile counter with strided linear address generation
module nest_tile_counter
  import nest_cnt_pkg::*;
#(
  parameter int CW   = 16,
  parameter int NEST = 3,
  parameter int AW   = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               abort,
  input  logic               ena,
  input  logic [NEST*CW-1:0] n_max,
  input  logic [NEST*AW-1:0] stride,
  input  logic [AW-1:0]      base,
  output logic [NEST*CW-1:0] cnt,
  output logic [AW-1:0]      addr,
  output logic               valid,
  output logic               last,
  output logic               done,
  output logic               busy,
  output logic               cfg_err
);

  if (NEST < 1 || NEST > NEST_MAX) begin : g_bad_nest
    $error("nest_tile_counter: NEST must be in 1..4");
  end

  state_e             state_q;
  logic [NEST*CW-1:0] n_max_q;
  logic [NEST*AW-1:0] stride_q;
  logic [AW-1:0]      base_q;
  logic               valid_q, done_q, busy_q, cfg_err_q;

  logic [NEST:0]   carry;
  logic [NEST-1:0] at_max;
  logic [CW-1:0]   cnt_l [NEST];
  logic [AW-1:0]   off_l [NEST];
  logic            consume, cfg_ok;
  logic [AW-1:0]   addr_sum;

  assign consume  = valid_q & ena & ~abort;
  assign carry[0] = consume;

  for (genvar g = 0; g < NEST; g++) begin : g_lvl
    nest_cnt_level #(.CW(CW), .AW(AW)) u_lvl (
      .clk         (clk),
      .rst         (rst),
      .clear_i     (abort),
      .carry_in_i  (carry[g]),
      .max_i       (n_max_q[lvl_lo(g, CW) +: CW]),
      .stride_i    (stride_q[lvl_lo(g, AW) +: AW]),
      .cnt_o       (cnt_l[g]),
      .off_o       (off_l[g]),
      .at_max_o    (at_max[g]),
      .carry_out_o (carry[g+1])
    );
    assign cnt[lvl_lo(g, CW) +: CW] = cnt_l[g];
  end

  always_comb begin
    cfg_ok = 1'b1;
    for (int i = 0; i < NEST; i++) begin
      if (n_max[lvl_lo(i, CW) +: CW] == '0) cfg_ok = 1'b0;
    end
  end

  always_comb begin
    addr_sum = base_q;
    for (int i = 0; i < NEST; i++) addr_sum = addr_sum + off_l[i];
  end

  assign addr    = valid_q ? addr_sum : '0;
  assign last    = valid_q & (&at_max);
  assign valid   = valid_q;
  assign done    = done_q;
  assign busy    = busy_q;
  assign cfg_err = cfg_err_q;

  // carry[NEST] is exactly the consumption of the final tuple.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      n_max_q   <= '0;
      stride_q  <= '0;
      base_q    <= '0;
      valid_q   <= 1'b0;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
      cfg_err_q <= 1'b0;
    end else begin
      done_q    <= 1'b0;
      cfg_err_q <= 1'b0;
      if (abort) begin
        state_q <= ST_IDLE;
        valid_q <= 1'b0;
        busy_q  <= 1'b0;
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (start) begin
              if (cfg_ok) begin
                n_max_q  <= n_max;
                stride_q <= stride;
                base_q   <= base;
                state_q  <= ST_RUN;
                valid_q  <= 1'b1;
                busy_q   <= 1'b1;
              end else begin
                cfg_err_q <= 1'b1;
              end
            end
          end
          ST_RUN: begin
            if (carry[NEST]) begin
              state_q <= ST_FIN;
              valid_q <= 1'b0;
              done_q  <= 1'b1;
            end
          end
          ST_FIN: begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end
          default: begin
            state_q <= ST_IDLE;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_nest_tile_counter.sv
// tb/tb_nest_tile_counter.sv - scoreboard bench for nest_tile_counter (NEST=3, CW=16, AW=32)
module tb_nest_tile_counter;

  localparam int CW = 16;
  localparam int NEST = 3;
  localparam int AW = 32;

  typedef struct {
    logic [NEST*CW-1:0] cnt;
    logic [AW-1:0]      addr;
    logic               last;
  } exp_t;

  logic               clk = 1'b0;
  logic               rst, start, abort, ena;
  logic [NEST*CW-1:0] n_max;
  logic [NEST*AW-1:0] stride;
  logic [AW-1:0]      base;
  logic [NEST*CW-1:0] cnt;
  logic [AW-1:0]      addr;
  logic               valid, last, done, busy, cfg_err;

  exp_t sb[$];
  int   n_compared = 0;
  int   n_mismatched = 0;

  nest_tile_counter #(.CW(CW), .NEST(NEST), .AW(AW)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .ena(ena),
    .n_max(n_max), .stride(stride), .base(base),
    .cnt(cnt), .addr(addr), .valid(valid), .last(last),
    .done(done), .busy(busy), .cfg_err(cfg_err)
  );

  initial forever #5 clk = ~clk;

  // Reference walk: decompose a linear index into digits and multiply out the address.
  task automatic push_model(input logic [NEST*CW-1:0] nm, input logic [NEST*AW-1:0] st,
                            input logic [AW-1:0] b);
    int   total;
    int   rem;
    int   n;
    exp_t e;
    total = 1;
    for (int l = 0; l < NEST; l++) total = total * int'(nm[l*CW +: CW]);
    for (int idx = 0; idx < total; idx++) begin
      rem = idx;
      e.addr = b;
      e.cnt = '0;
      for (int l = 0; l < NEST; l++) begin
        n = int'(nm[l*CW +: CW]);
        e.cnt[l*CW +: CW] = CW'(rem % n);
        e.addr = e.addr + AW'(rem % n) * st[l*AW +: AW];
        rem = rem / n;
      end
      e.last = (idx == total - 1);
      sb.push_back(e);
    end
  endtask

  task automatic do_start(input logic [NEST*CW-1:0] nm, input logic [NEST*AW-1:0] st,
                          input logic [AW-1:0] b);
    bit ok;
    ok = 1'b1;
    for (int l = 0; l < NEST; l++) if (nm[l*CW +: CW] == '0) ok = 1'b0;
    if (ok) push_model(nm, st, b);
    n_max = nm; stride = st; base = b; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n_max = {$urandom, $urandom};
    stride = {$urandom, $urandom, $urandom};
    base = $urandom;
  endtask

  // Called on the negedge right after start; consumes the whole scoreboard.
  task automatic walk(input int pct, input bit poke, output int consumed);
    int guard;
    bit check_err;
    bit poked;
    guard = 0; consumed = 0; check_err = 0; poked = 0;
    while (sb.size() > 0 && guard < 400) begin
      guard++;
      start = 1'b0;
      if (check_err) begin
        check_err = 0;
        n_compared++;
        if (cfg_err !== 1'b0 || busy !== 1'b1) begin
          n_mismatched++;
          $display("FAIL start_in_run: cfg_err=%b busy=%b expected cfg_err=0 busy=1", cfg_err, busy);
        end
      end
      if (valid === 1'b1) begin
        n_compared++;
        if (cnt !== sb[0].cnt || addr !== sb[0].addr || last !== sb[0].last) begin
          n_mismatched++;
          $display("FAIL tuple: cnt=%h addr=%h last=%b expected cnt=%h addr=%h last=%b",
                   cnt, addr, last, sb[0].cnt, sb[0].addr, sb[0].last);
        end
        if (poke && !poked && consumed == 5) begin
          start = 1'b1; n_max = '0; poked = 1; check_err = 1;
        end
        ena = ($urandom_range(0, 99) < pct);
        if (ena) begin
          void'(sb.pop_front());
          consumed++;
        end
      end else begin
        n_compared++;
        n_mismatched++;
        $display("FAIL valid_in_run: valid=%b expected 1", valid);
        ena = $urandom_range(0, 1);
      end
      @(negedge clk);
    end
    ena = 1'b0;
    start = 1'b0;
    n_compared++;
    if (sb.size() != 0) begin
      n_mismatched++;
      $display("FAIL walk_timeout: %0d tuples left expected 0", sb.size());
      sb.delete();
    end
    n_compared++;
    if (done !== 1'b1 || valid !== 1'b0 || busy !== 1'b1) begin
      n_mismatched++;
      $display("FAIL fin: done=%b valid=%b busy=%b expected 1 0 1", done, valid, busy);
    end
    @(negedge clk);
    n_compared++;
    if (done !== 1'b0 || busy !== 1'b0 || valid !== 1'b0 || cnt !== '0 || addr !== '0) begin
      n_mismatched++;
      $display("FAIL idle_after: done=%b busy=%b valid=%b cnt=%h addr=%h expected all 0",
               done, busy, valid, cnt, addr);
    end
  endtask

  localparam logic [NEST*CW-1:0] NM_A = {16'd2, 16'd3, 16'd4};
  localparam logic [NEST*AW-1:0] ST_A = {32'd12, 32'd4, 32'd1};

  task automatic test_reset();
    rst = 1'b1; start = 0; abort = 0; ena = 0; n_max = '0; stride = '0; base = '0;
    repeat (3) @(negedge clk);
    n_compared++;
    if (cnt !== '0 || addr !== '0 || valid !== 0 || last !== 0 || done !== 0 || busy !== 0 || cfg_err !== 0) begin
      n_mismatched++;
      $display("FAIL reset: cnt=%h addr=%h valid=%b last=%b done=%b busy=%b cfg_err=%b expected all 0",
               cnt, addr, valid, last, done, busy, cfg_err);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_full_walk();
    int c;
    do_start(NM_A, ST_A, 32'h100);
    walk(100, 0, c);
    n_compared++;
    if (c != 24) begin
      n_mismatched++;
      $display("FAIL full_count: consumed=%0d expected 24", c);
    end
  endtask

  task automatic test_random_ena();
    int c;
    do_start(NM_A, ST_A, 32'h100);
    walk(50, 0, c);
    n_compared++;
    if (c != 24) begin
      n_mismatched++;
      $display("FAIL rand_count: consumed=%0d expected 24", c);
    end
  endtask

  task automatic test_cfg_err();
    do_start({16'd2, 16'd3, 16'd0}, ST_A, 32'h100);
    n_compared++;
    if (cfg_err !== 1'b1 || busy !== 0 || valid !== 0 || done !== 0) begin
      n_mismatched++;
      $display("FAIL cfg_err_pulse: cfg_err=%b busy=%b valid=%b done=%b expected 1 0 0 0",
               cfg_err, busy, valid, done);
    end
    @(negedge clk);
    n_compared++;
    if (cfg_err !== 1'b0 || busy !== 0 || valid !== 0 || done !== 0) begin
      n_mismatched++;
      $display("FAIL cfg_err_clear: cfg_err=%b busy=%b valid=%b done=%b expected all 0",
               cfg_err, busy, valid, done);
    end
  endtask

  task automatic test_single();
    int c;
    do_start({16'd1, 16'd1, 16'd1}, ST_A, 32'h40);
    n_compared++;
    if (valid !== 1'b1 || last !== 1'b1) begin
      n_mismatched++;
      $display("FAIL single_first: valid=%b last=%b expected 1 1", valid, last);
    end
    walk(100, 0, c);
  endtask

  task automatic test_abort(input bit use_rst);
    int c;
    do_start(NM_A, ST_A, 32'h100);
    for (int k = 0; k < 10; k++) begin
      n_compared++;
      if (valid !== 1'b1 || cnt !== sb[0].cnt || addr !== sb[0].addr) begin
        n_mismatched++;
        $display("FAIL pre_abort: valid=%b cnt=%h addr=%h expected 1 %h %h",
                 valid, cnt, addr, sb[0].cnt, sb[0].addr);
      end
      ena = 1'b1;
      void'(sb.pop_front());
      @(negedge clk);
    end
    if (use_rst) rst = 1'b1; else abort = 1'b1;
    start = 1'b1; n_max = NM_A; stride = ST_A; base = 32'h100;
    @(negedge clk);
    rst = 0; abort = 0; start = 0; ena = 0;
    sb.delete();
    n_compared++;
    if (busy !== 0 || valid !== 0 || cnt !== '0 || addr !== '0 || done !== 0) begin
      n_mismatched++;
      $display("FAIL abort_idle: busy=%b valid=%b cnt=%h addr=%h done=%b expected all 0",
               busy, valid, cnt, addr, done);
    end
    @(negedge clk);
    n_compared++;
    if (done !== 0 || busy !== 0) begin
      n_mismatched++;
      $display("FAIL abort_no_done: done=%b busy=%b expected 0 0", done, busy);
    end
    do_start(NM_A, ST_A, 32'h100);
    walk(100, 0, c);
  endtask

  task automatic test_wrap();
    int c;
    do_start({16'd4, 16'd2, 16'd2}, {32'h8000_0000, 32'h10, 32'h3}, 32'hFFFF_FFF0);
    walk(70, 1, c);
    n_compared++;
    if (c != 16) begin
      n_mismatched++;
      $display("FAIL wrap_count: consumed=%0d expected 16", c);
    end
  endtask

  initial begin
    test_reset();
    test_full_walk();
    test_random_ena();
    test_cfg_err();
    test_single();
    test_abort(1'b0);
    test_abort(1'b1);
    test_wrap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule

// File: doc/nest_tile_counter.md
# nest_tile_counter

Parametrised N-level nested tile counter with strided address generation. It is the general replacement for the fixed two-level output-feature-map store counter. A `start` pulse latches a per-level trip count, a per-level stride and a base address. The block then walks every index tuple, level 0 innermost, presenting one tuple and its linear address per consumed cycle under a valid/ena handshake, and ends with a one-cycle `done`. It sits between the tile controllers (load/store of in_fm, weights, out_fm) and the memory-request ports.

## Interface
Parameters:
- `CW`, 16: counter width per level.
- `NEST`, 3: number of nest levels, legal range 1..4.
- `AW`, 32: address width.

Ports:
- `clk`  in  1: clock.
- `rst`  in  1: reset. Reset is synchronous and active-high, and is the block's only reset; there is one clock.
- `start`  in  1: pulse that latches the configuration and begins a walk. Honoured only in IDLE.
- `abort`  in  1: synchronous abort of the walk; no `done` is issued.
- `ena`  in  1: consumer accepts the current tuple.
- `n_max`  in  NEST*CW: per-level trip counts, level 0 in bits [CW-1:0].
- `stride`  in  NEST*AW: per-level address strides, level 0 in the LSBs.
- `base`  in  AW: base address.
- `cnt`  out  NEST*CW: current index tuple, same packing as `n_max`.
- `addr`  out  AW: `base` + Σ `cnt[i]`*`stride[i]`, modulo 2^AW.
- `valid`  out  1: `cnt`/`addr` hold a tuple that has not yet been consumed.
- `last`  out  1: `valid` and the current tuple is the final one.
- `done`  out  1: one-cycle pulse after the final tuple is consumed.
- `busy`  out  1: state is not IDLE.
- `cfg_err`  out  1: one-cycle pulse when `start` is rejected.

## Operation
- States are IDLE, RUN and FIN.
- IDLE:
  - `cnt`=0, `addr`=0, `valid`=0.
  - On `start` with every `n_max[i]`≥1: latch `n_max`, `stride` and `base`; go to RUN with `cnt`=0 and `addr`=`base`.
  - On `start` with any `n_max[i]`==0: pulse `cfg_err` next cycle and stay in IDLE.
- RUN:
  - `valid`=1.
  - A tuple is consumed when `valid`&`ena`. On consumption, level 0 increments.
  - Level i wraps to 0 when it is at `n_max[i]`-1 and receives a carry; the wrap carries into level i+1.
  - Level 0 always receives a carry on consumption.
- Final tuple: every `cnt[i]`==`n_max[i]`-1. Consuming it moves the state to FIN with `valid`=0.
- FIN: lasts one cycle. `done`=1 and `cnt`=0, then the state returns to IDLE.
- A level with `n_max`=1 stays at 0 and always passes the carry on.
- Total tuples = Π `n_max[i]`. Throughput is one tuple per cycle while `ena` is held.
- Address is maintained incrementally, with no multipliers:
  - Each level keeps an offset register `off[i]` = `cnt[i]`*`stride[i]`.
  - On increment, `off[i]` += `stride[i]`; on wrap, `off[i]` is cleared to 0.
  - `addr` = `base` + Σ`off[i]`. The adder is combinational from registers.
- `start` in RUN or FIN is ignored and does not raise `cfg_err`.
- `abort`, in any state, moves to IDLE next cycle with `cnt`/`off` cleared. `abort` wins over a simultaneous `ena` or `start`.
- `rst` has the same effect as `abort` and also clears `cfg_err`/`done`.
- Configuration inputs are don't-care outside the `start` cycle.

## Timing
- Reset values: `cnt`=0, `addr`=0, `valid`=0, `last`=0, `done`=0, `busy`=0, `cfg_err`=0, state IDLE.
- `start` at cycle t → `valid`=1 and `addr`=`base` at t+1.
- Consumption at cycle t → the next tuple is visible at t+1.
- Final consumption at t → `done` at t+1, IDLE at t+2. A new `start` is accepted at t+2.
- `last` is combinational from `cnt` and the latched `n_max`; `addr` is combinational from the offsets.
- All other outputs are registered.
- `ena` while `valid`=0 has no effect.

## Structure
- Package `nest_cnt_pkg`:
  - state enum (IDLE/RUN/FIN);
  - `NEST_MAX`=4;
  - helper functions for slicing level i out of the packed buses.
- Sub-module `nest_cnt_level`, instantiated NEST times by generate.
  - Inputs: `carry_in`, latched max, latched stride, clear.
  - Outputs: `cnt`, `off`, `at_max`, `carry_out` (`carry_in` & `at_max`).
- The top level holds the FSM, the configuration latches, the address adder and `last`/`done`.

## Test plan
- NEST=3, `n_max`={4,3,2} (level0..2), `stride`={1,4,12}, `base`=0x100, `ena` high → 24 tuples with `addr` 0x100..0x117 consecutive; `last` only on the 24th; `done` one cycle later; `busy` low after.
- Same configuration with `ena` randomly 50% → the identical 24-tuple sequence; `cnt`/`addr` held stable while `ena`=0; no tuple skipped or repeated.
- `n_max`={0,3,2} with `start` → `cfg_err` for one cycle; `busy`, `valid` and `done` stay 0.
- `n_max`={1,1,1}, `ena` high, `start` at t → `valid`=`last`=1 at t+1, `done` at t+2.
- `abort` (then, in a separate run, `rst`) asserted after the 10th consumption → IDLE next cycle, `cnt`=0, no `done`. A following `start` restarts from `base`.
- `stride` with `base`=0xFFFF_FFF0, AW=32 → `addr` wraps modulo 2^32. `start` pulsed during RUN is ignored.
